// File: rtl/stream_buffer_reader.sv
// Repacks a first-word-fall-through stream of 40-bit FIFO words into 32-bit output words, LSB-first.
// A flush request emits any trailing partial word, zero-padded, once the FIFO has drained.
module stream_buffer_reader (
    input  logic        clk,
    input  logic        reset,
    input  logic        fifo_empty,
    input  logic [39:0] fifo_data,
    output logic        fifo_rd_en,
    input  logic        flush,
    output logic [31:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic [15:0] words_in,
    output logic [15:0] words_out,
    output logic        busy
);

    typedef enum logic {RUN, PAD} state_t;

    state_t      state;
    logic [71:0] acc;
    logic [6:0]  lvl;
    logic        flush_pend;

    logic        pop;
    logic        take;
    logic [71:0] acc_fill;
    logic [6:0]  lvl_fill;

    // Pop only while fewer than 32 bits are buffered, so a 40-bit word always fits (max 71).
    assign pop        = (state == RUN) && !fifo_empty && (lvl < 7'd32) && !reset;
    assign fifo_rd_en = pop;
    assign dout_valid = (state == PAD) || (lvl >= 7'd32);
    assign dout       = acc[31:0];
    assign take       = dout_valid && dout_ready;
    assign busy       = (state == PAD) || (lvl != 7'd0) || flush_pend;

    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred.
        acc_fill = acc;
        lvl_fill = lvl;
        if (pop) begin
            acc_fill = acc | ({32'd0, fifo_data} << lvl);
            lvl_fill = lvl + 7'd40;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            acc        <= '0;
            lvl        <= '0;
            flush_pend <= 1'b0;
            words_in   <= '0;
            words_out  <= '0;
        end else begin
            if (pop)
                words_in <= words_in + 16'd1;
            if (take)
                words_out <= words_out + 16'd1;

            case (state)
                RUN: begin
                    // The append uses the pre-shift level; the shift applies to the merged result.
                    if (take) begin
                        acc <= acc_fill >> 32;
                        lvl <= lvl_fill - 7'd32;
                    end else begin
                        acc <= acc_fill;
                        lvl <= lvl_fill;
                    end

                    if (flush_pend && fifo_empty && !pop && (lvl != 7'd0) && (lvl < 7'd32))
                        state <= PAD;

                    if (flush)
                        flush_pend <= 1'b1;
                    else if (flush_pend && fifo_empty && (lvl == 7'd0))
                        flush_pend <= 1'b0;
                end

                PAD: begin
                    if (take) begin
                        acc        <= '0;
                        lvl        <= '0;
                        flush_pend <= 1'b0;
                        state      <= RUN;
                    end
                end

                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_buffer_reader.sv
// Directed bench for stream_buffer_reader: a queue models the FWFT FIFO, taken words are logged.
// Inputs change on the falling edge; outputs are sampled 1 ns later, before the next rising edge.
module tb_stream_buffer_reader;

    logic        clk;
    logic        reset;
    logic        fifo_empty;
    logic [39:0] fifo_data;
    logic        fifo_rd_en;
    logic        flush;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic [15:0] words_in;
    logic [15:0] words_out;
    logic        busy;

    stream_buffer_reader dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .flush      (flush),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .words_in   (words_in),
        .words_out  (words_out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [39:0] fifo_q[$];
    logic [31:0] out_q[$];
    int          pops;
    int          n_checks;
    int          n_pass;
    logic        obs_valid;
    logic [31:0] obs_dout;
    logic        obs_busy;
    logic        obs_rd_en;

    // One clock cycle: drive FIFO view, sample outputs, then apply the pop/take that the edge performed.
    task automatic cycle(input logic flush_in);
        logic        pop_seen;
        logic        take_seen;
        logic [31:0] tdata;
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 40'd0 : fifo_q[0];
        flush      = flush_in;
        #1;
        pop_seen  = fifo_rd_en;
        take_seen = dout_valid && dout_ready;
        tdata     = dout;
        obs_valid = dout_valid;
        obs_dout  = dout;
        obs_busy  = busy;
        obs_rd_en = fifo_rd_en;
        @(posedge clk);
        if (pop_seen && fifo_q.size() > 0) begin
            fifo_q.delete(0);
            pops++;
        end
        if (take_seen)
            out_q.push_back(tdata);
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic run_until(input int n, input int budget);
        for (int k = 0; k < budget && out_q.size() < n; k++)
            cycle(1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        fifo_q.delete();
        cycle(1'b0);
        reset = 1'b0;
        out_q.delete();
        pops = 0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        dout_ready = 1'b1;
        fifo_q.delete();
        fifo_q.push_back(40'h00_0000_0001);
        cycle(1'b0);
        cycle(1'b0);
        n_checks++; if (obs_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b expected 0", obs_rd_en); else n_pass++;
        fifo_q.delete();
        reset = 1'b0;
        n_checks++; if (dout_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", dout_valid); else n_pass++;
        n_checks++; if (dout !== 32'd0) $display("FAIL reset_dout: got %h expected 00000000", dout); else n_pass++;
        n_checks++; if (words_in !== 16'd0) $display("FAIL reset_words_in: got %0d expected 0", words_in); else n_pass++;
        n_checks++; if (words_out !== 16'd0) $display("FAIL reset_words_out: got %0d expected 0", words_out); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        cycle(1'b0);
        n_checks++; if (obs_rd_en !== 1'b0 || obs_valid !== 1'b0) $display("FAIL reset_idle: got rd_en=%b valid=%b expected 0 0", obs_rd_en, obs_valid); else n_pass++;
    endtask

    task automatic test_basic_packing();
        do_reset();
        dout_ready = 1'b1;
        fifo_q.push_back(40'hAA_0000_0001);
        fifo_q.push_back(40'hBB_0000_0002);
        cycle(1'b0);
        n_checks++; if (obs_rd_en !== 1'b1) $display("FAIL basic_pop_latency: got %b expected 1", obs_rd_en); else n_pass++;
        cycle(1'b0);
        n_checks++; if (obs_valid !== 1'b1) $display("FAIL basic_valid_latency: got %b expected 1", obs_valid); else n_pass++;
        run_until(2, 20);
        n_checks++; if (out_q.size() != 2) $display("FAIL basic_count: got %0d expected 2", out_q.size()); else n_pass++;
        if (out_q.size() >= 2) begin
            n_checks++; if (out_q[0] !== 32'h0000_0001) $display("FAIL basic_out0: got %h expected 00000001", out_q[0]); else n_pass++;
            n_checks++; if (out_q[1] !== 32'h0000_02AA) $display("FAIL basic_out1: got %h expected 000002aa", out_q[1]); else n_pass++;
        end
        n_checks++; if (words_in !== 16'd2) $display("FAIL basic_words_in: got %0d expected 2", words_in); else n_pass++;
        // 16 bits (0xBB00) remain; a flush must push them out through PAD.
        cycle(1'b1);
        run_until(3, 20);
        n_checks++; if (out_q.size() != 3) $display("FAIL basic_flush_count: got %0d expected 3", out_q.size()); else n_pass++;
        if (out_q.size() >= 3) begin
            n_checks++; if (out_q[2] !== 32'h0000_BB00) $display("FAIL basic_flush_out: got %h expected 0000bb00", out_q[2]); else n_pass++;
        end
        n_checks++; if (words_out !== 16'd3) $display("FAIL basic_words_out: got %0d expected 3", words_out); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy: got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_whole_group();
        logic [31:0] exp_out[5];
        exp_out = '{32'h2233_4455, 32'h3344_5511, 32'h4455_1122, 32'h5511_2233, 32'h1122_3344};
        do_reset();
        dout_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            fifo_q.push_back(40'h11_2233_4455);
        run_until(6, 40);
        n_checks++; if (out_q.size() != 5) $display("FAIL group_count: got %0d expected 5", out_q.size()); else n_pass++;
        for (int j = 0; j < 5 && j < out_q.size(); j++) begin
            n_checks++; if (out_q[j] !== exp_out[j]) $display("FAIL group_out%0d: got %h expected %h", j, out_q[j], exp_out[j]); else n_pass++;
        end
        n_checks++; if (busy !== 1'b0) $display("FAIL group_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (words_in !== 16'd4) $display("FAIL group_words_in: got %0d expected 4", words_in); else n_pass++;
        n_checks++; if (words_out !== 16'd5) $display("FAIL group_words_out: got %0d expected 5", words_out); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [39:0] w;
        logic [31:0] e;
        logic        unstable;
        do_reset();
        dout_ready = 1'b0;
        // Byte k of the input stream carries value k, so output j is bytes 4j+3..4j.
        for (int i = 0; i < 8; i++) begin
            w = '0;
            for (int b = 0; b < 5; b++)
                w[8*b +: 8] = 8'(5*i + b);
            fifo_q.push_back(w);
        end
        unstable = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cycle(1'b0);
            if (obs_valid && obs_dout !== 32'h0302_0100)
                unstable = 1'b1;
        end
        n_checks++; if (pops != 1) $display("FAIL bp_pops: got %0d expected 1", pops); else n_pass++;
        n_checks++; if (obs_valid !== 1'b1) $display("FAIL bp_valid: got %b expected 1", obs_valid); else n_pass++;
        n_checks++; if (unstable !== 1'b0) $display("FAIL bp_dout_stable: got unstable=%b expected 0", unstable); else n_pass++;
        dout_ready = 1'b1;
        run_until(11, 80);
        n_checks++; if (out_q.size() != 10) $display("FAIL bp_count: got %0d expected 10", out_q.size()); else n_pass++;
        for (int j = 0; j < 10 && j < out_q.size(); j++) begin
            e = {8'(4*j + 3), 8'(4*j + 2), 8'(4*j + 1), 8'(4*j)};
            n_checks++; if (out_q[j] !== e) $display("FAIL bp_out%0d: got %h expected %h", j, out_q[j], e); else n_pass++;
        end
        n_checks++; if (busy !== 1'b0) $display("FAIL bp_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (words_in !== 16'd8) $display("FAIL bp_words_in: got %0d expected 8", words_in); else n_pass++;
    endtask

    task automatic test_flush_partial();
        do_reset();
        dout_ready = 1'b1;
        fifo_q.push_back(40'hCC_1234_5678);
        cycle(1'b1);
        run_until(3, 20);
        n_checks++; if (out_q.size() != 2) $display("FAIL flush_count: got %0d expected 2", out_q.size()); else n_pass++;
        if (out_q.size() >= 2) begin
            n_checks++; if (out_q[0] !== 32'h1234_5678) $display("FAIL flush_out0: got %h expected 12345678", out_q[0]); else n_pass++;
            n_checks++; if (out_q[1] !== 32'h0000_00CC) $display("FAIL flush_out1: got %h expected 000000cc", out_q[1]); else n_pass++;
        end
        n_checks++; if (words_out !== 16'd2) $display("FAIL flush_words_out: got %0d expected 2", words_out); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL flush_busy: got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_flush_idle();
        int   busy_cnt;
        logic valid_seen;
        do_reset();
        dout_ready = 1'b1;
        cycle(1'b1);
        busy_cnt   = 0;
        valid_seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cycle(1'b0);
            if (obs_busy) busy_cnt++;
            if (obs_valid) valid_seen = 1'b1;
        end
        n_checks++; if (busy_cnt != 1) $display("FAIL idle_busy_cycles: got %0d expected 1", busy_cnt); else n_pass++;
        n_checks++; if (valid_seen !== 1'b0) $display("FAIL idle_valid: got %b expected 0", valid_seen); else n_pass++;
        n_checks++; if (words_out !== 16'd0) $display("FAIL idle_words_out: got %0d expected 0", words_out); else n_pass++;
    endtask

    task automatic test_reset_in_pad();
        do_reset();
        dout_ready = 1'b1;
        fifo_q.push_back(40'hDD_8765_4321);
        cycle(1'b1);
        cycle(1'b0);
        dout_ready = 1'b0;
        cycle(1'b0);
        fifo_q.push_back(40'h00_CAFE_F00D);
        cycle(1'b0);
        n_checks++; if (obs_valid !== 1'b1 || obs_dout !== 32'h0000_00DD) $display("FAIL pad_out: got valid=%b dout=%h expected 1 000000dd", obs_valid, obs_dout); else n_pass++;
        n_checks++; if (obs_rd_en !== 1'b0) $display("FAIL pad_no_pop: got %b expected 0", obs_rd_en); else n_pass++;
        reset = 1'b1;
        cycle(1'b0);
        reset = 1'b0;
        out_q.delete();
        n_checks++; if (dout_valid !== 1'b0) $display("FAIL rpad_valid: got %b expected 0", dout_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rpad_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (words_in !== 16'd0 || words_out !== 16'd0) $display("FAIL rpad_counters: got %0d/%0d expected 0/0", words_in, words_out); else n_pass++;
        cycle(1'b0);
        n_checks++; if (obs_valid !== 1'b0) $display("FAIL rpad_next_valid: got %b expected 0", obs_valid); else n_pass++;
        dout_ready = 1'b1;
        run_until(1, 20);
        n_checks++; if (out_q.size() < 1) $display("FAIL rpad_count: got %0d expected 1", out_q.size()); else n_pass++;
        if (out_q.size() >= 1) begin
            n_checks++; if (out_q[0] !== 32'hCAFE_F00D) $display("FAIL rpad_out: got %h expected cafef00d", out_q[0]); else n_pass++;
        end
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        pops       = 0;
        reset      = 1'b1;
        flush      = 1'b0;
        dout_ready = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        test_reset();
        test_basic_packing();
        test_whole_group();
        test_backpressure();
        test_flush_partial();
        test_flush_idle();
        test_reset_in_pad();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
